// File: rtl/rc4_pkg.sv
// Shared types for the RC4 S-memory sequencer and its engines.
// Holds the sequencer state encoding and the engine phase indices.
package rc4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_DROP,
        WAIT_DONE,
        DONE,
        ERR
    } seq_state_t;

    localparam logic [1:0] PH_INIT = 2'd0;
    localparam logic [1:0] PH_KSA  = 2'd1;
    localparam logic [1:0] PH_PRGA = 2'd2;

endpackage

// File: rtl/s_mem_mux.sv
// Combinational owner select of the S memory write port.
// Only the engine named by sel reaches the RAM, and only while own is high.
module s_mem_mux #(
    parameter int NUM_ENG = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                      own,
    input  logic [1:0]                sel,
    input  logic [NUM_ENG*ADDR_W-1:0] eng_addr,
    input  logic [NUM_ENG*DATA_W-1:0] eng_wrdata,
    input  logic [NUM_ENG-1:0]        eng_wren,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wrdata,
    output logic                      mem_wren
);

    always_comb begin
        mem_addr   = '0;
        mem_wrdata = '0;
        mem_wren   = 1'b0;
        for (int k = 0; k < NUM_ENG; k++) begin
            if (own && sel == 2'(k)) begin
                mem_addr   = eng_addr[k*ADDR_W +: ADDR_W];
                mem_wrdata = eng_wrdata[k*DATA_W +: DATA_W];
                mem_wren   = eng_wren[k];
            end
        end
    end

endmodule

// File: rtl/s_mem_sequencer.sv
// Runs init, ksa and prga in order and hands the S memory to whichever
// engine is active; a per-phase watchdog flags an engine that never returns.
module s_mem_sequencer
    import rc4_pkg::*;
#(
    parameter int NUM_ENG = 3,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                phase,
    output logic [NUM_ENG-1:0]        eng_en,
    input  logic [NUM_ENG-1:0]        eng_rdy,
    input  logic [NUM_ENG*ADDR_W-1:0] eng_addr,
    input  logic [NUM_ENG*DATA_W-1:0] eng_wrdata,
    input  logic [NUM_ENG-1:0]        eng_wren,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wrdata,
    output logic                      mem_wren
);

    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);
    localparam logic [1:0]      LAST   = 2'(NUM_ENG - 1);

    seq_state_t      state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            rdy_cur;
    logic            expired;
    logic            own;

    assign rdy_cur = eng_rdy[phase_q];
    assign expired = (wdog_q == WD_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= PH_INIT;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wdog_d  = wdog_q;
        eng_en  = '0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LAUNCH;
                    phase_d = PH_INIT;
                    wdog_d  = '0;
                end
            end
            LAUNCH: begin
                if (rdy_cur) begin
                    eng_en[phase_q] = 1'b1;
                    // the launch cycle itself counts toward the phase budget
                    wdog_d  = WD_W'(1);
                    state_d = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                wdog_d = WD_W'(wdog_q + 1'b1);
                if (expired) begin
                    state_d = ERR;
                    phase_d = PH_INIT;
                end else if (!rdy_cur) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wdog_d = WD_W'(wdog_q + 1'b1);
                if (expired) begin
                    state_d = ERR;
                    phase_d = PH_INIT;
                end else if (rdy_cur) begin
                    if (phase_q == LAST) begin
                        state_d = DONE;
                        phase_d = PH_INIT;
                    end else begin
                        state_d = LAUNCH;
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == LAUNCH) || (state_q == WAIT_DROP) ||
                   (state_q == WAIT_DONE);
    assign done  = (state_q == DONE);
    assign error = (state_q == ERR);
    assign phase = phase_q;
    // keep the RAM write port quiet while reset is held
    assign own   = busy && !rst;

    s_mem_mux #(
        .NUM_ENG(NUM_ENG),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .own       (own),
        .sel       (phase_q),
        .eng_addr  (eng_addr),
        .eng_wrdata(eng_wrdata),
        .eng_wren  (eng_wren),
        .mem_addr  (mem_addr),
        .mem_wrdata(mem_wrdata),
        .mem_wren  (mem_wren)
    );

endmodule
